// File: rtl/uart_rx_frame.sv
// UART receiver: start, DATA_BITS data (LSB first), parity, stop; valid/ready parallel output.
// Optional macro UART_RX_SYNC_EN adds a 2-flop synchronizer on rx (+2 cycles latency).
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk_uart,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    BIT_LAST = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_WAIT_HIGH, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 perr;
        logic                 ferr;
    } frame_t;

    state_t               state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_mis;
    logic                 stop_low;
    logic                 done_q;
    logic                 rx_s;
    logic                 exp_par;
    logic                 mid_tick, end_tick;
    logic                 start_ok, bit_tick, par_tick, stop_tick;
    frame_t               pend;

`ifdef UART_RX_SYNC_EN
    logic [1:0] rx_sync;
    always_ff @(posedge clk_uart or negedge rst) begin
        if (!rst) rx_sync <= 2'b11;
        else      rx_sync <= {rx_sync[0], rx};
    end
    assign rx_s = rx_sync[1];
`else
    assign rx_s = rx;
`endif

    assign exp_par = (PARITY_ODD != 0) ? ~^shift : ^shift;

    always_ff @(posedge clk_uart or negedge rst) begin
        if (!rst) state <= S_WAIT_HIGH;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_WAIT_HIGH: if (rx_s)  state_nx = S_IDLE;
            S_IDLE:      if (!rx_s) state_nx = S_START;
            S_START:     if (mid_tick) state_nx = rx_s ? S_IDLE : S_DATA;
            S_DATA:      if (end_tick && bit_idx == BIT_LAST) state_nx = S_PARITY;
            S_PARITY:    if (end_tick) state_nx = S_STOP;
            // A low stop bit means a break or framing fault: wait for the line to recover.
            S_STOP:      if (end_tick) state_nx = rx_s ? S_IDLE : S_WAIT_HIGH;
            default:     state_nx = S_WAIT_HIGH;
        endcase
    end

    always_comb begin
        mid_tick  = (cnt == HALF_M1);
        end_tick  = (cnt == FULL_M1);
        start_ok  = (state == S_START)  && mid_tick && !rx_s;
        bit_tick  = (state == S_DATA)   && end_tick;
        par_tick  = (state == S_PARITY) && end_tick;
        stop_tick = (state == S_STOP)   && end_tick;
        cnt_nx    = cnt + 1'b1;
        if (state == S_WAIT_HIGH || state == S_IDLE)
            cnt_nx = '0;
        else if ((state == S_START && mid_tick) || (state != S_START && end_tick))
            cnt_nx = '0;
    end

    always_comb begin
        pend.data = shift;
        pend.perr = par_mis;
        pend.ferr = stop_low;
    end

    always_ff @(posedge clk_uart or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par_mis  <= 1'b0;
            stop_low <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt    <= cnt_nx;
            done_q <= stop_tick;
            if (start_ok) bit_idx <= '0;
            if (bit_tick) begin
                bit_idx <= bit_idx + 4'd1;
                for (int i = 0; i < DATA_BITS; i++)
                    if (bit_idx == 4'(i)) shift[i] <= rx_s;
            end
            if (par_tick)  par_mis  <= rx_s ^ exp_par;
            if (stop_tick) stop_low <= !rx_s;
        end
    end

    // Completed frame is offered one cycle after the stop sample; a full holding
    // register drops the new frame unless it is being accepted on that same edge.
    always_ff @(posedge clk_uart or negedge rst) begin
        if (!rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            busy        <= (state_nx != S_IDLE);
            if (done_q) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= pend.data;
                    parity_err <= pend.perr;
                    frame_err  <= pend.ferr;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with default parameters: table of frames plus corner sequences.
module tb_uart_rx_frame;
    localparam int CPB = 16;
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk_uart = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, overrun_err, busy;

    int checks = 0;
    int failures = 0;
    int ovr_cnt = 0;
    int ovr_base;

    uart_rx_frame dut (
        .clk_uart    (clk_uart),
        .rst         (rst),
        .rx          (rx),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk_uart = ~clk_uart;

    always @(negedge clk_uart) if (overrun_err) ovr_cnt++;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic [7:0] ed;
        logic       ep;
        logic       ef;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives one full frame, each bit for CPB cycles.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit keep_low);
        rx = 1'b0;
        repeat (CPB) @(negedge clk_uart);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk_uart);
        end
        rx = p;
        repeat (CPB) @(negedge clk_uart);
        rx = s;
        repeat (CPB) @(negedge clk_uart);
        rx = keep_low ? 1'b0 : 1'b1;
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        @(negedge clk_uart);
        rx_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{d: 8'h37, p: 1'b0, s: 1'b1, ed: 8'h37, ep: 1'b1, ef: 1'b0};
        vecs[1] = '{d: 8'h00, p: 1'b0, s: 1'b1, ed: 8'h00, ep: 1'b0, ef: 1'b0};
        vecs[2] = '{d: 8'hFF, p: 1'b0, s: 1'b1, ed: 8'hFF, ep: 1'b0, ef: 1'b0};
        vecs[3] = '{d: 8'h80, p: 1'b1, s: 1'b1, ed: 8'h80, ep: 1'b0, ef: 1'b0};
        vecs[4] = '{d: 8'h3C, p: 1'b1, s: 1'b1, ed: 8'h3C, ep: 1'b1, ef: 1'b0};
        vecs[5] = '{d: 8'hC3, p: 1'b0, s: 1'b0, ed: 8'hC3, ep: 1'b0, ef: 1'b1};
        vecs[6] = '{d: 8'h01, p: 1'b1, s: 1'b1, ed: 8'h01, ep: 1'b0, ef: 1'b0};

        // Reset values
        repeat (3) @(negedge clk_uart);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        repeat (3 + LAT) @(negedge clk_uart);
        chk("idle_busy", busy, 0);

        // 0xA5 good frame: latency boundary, then hold until accepted
        fork
            send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
            begin
                repeat (169 + LAT) @(negedge clk_uart);
                chk("lat_before", rx_valid, 0);
                @(negedge clk_uart);
                chk("lat_at", rx_valid, 1);
            end
        join
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_perr", parity_err, 0);
        chk("a5_ferr", frame_err, 0);
        repeat (20) @(negedge clk_uart);
        chk("a5_hold_valid", rx_valid, 1);
        chk("a5_hold_data", rx_data, 8'hA5);
        accept();
        chk("a5_cleared", rx_valid, 0);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].d, vecs[i].p, vecs[i].s, 1'b0);
            chk($sformatf("vec%0d_valid", i), rx_valid, 1);
            chk($sformatf("vec%0d_data", i), rx_data, vecs[i].ed);
            chk($sformatf("vec%0d_perr", i), parity_err, vecs[i].ep);
            chk($sformatf("vec%0d_ferr", i), frame_err, vecs[i].ef);
            accept();
            chk($sformatf("vec%0d_clr", i), rx_valid, 0);
            repeat (2) @(negedge clk_uart);
        end

        // Break: stop bit 0 and line held low for 50 bit times
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
        chk("brk_valid", rx_valid, 1);
        chk("brk_data", rx_data, 8'h0F);
        chk("brk_ferr", frame_err, 1);
        chk("brk_perr", parity_err, 0);
        chk("brk_busy", busy, 1);
        accept();
        repeat (50 * CPB) @(negedge clk_uart);
        chk("brk_no_frame", rx_valid, 0);
        chk("brk_busy_low", busy, 1);
        rx = 1'b1;
        repeat (3 + LAT) @(negedge clk_uart);
        chk("brk_recover", busy, 0);

        // False start: 4 low cycles
        rx = 1'b0;
        repeat (3) @(negedge clk_uart);
        chk("fs_busy", busy, 1);
        @(negedge clk_uart);
        rx = 1'b1;
        repeat (5 + LAT) @(negedge clk_uart);
        chk("fs_busy_clr", busy, 0);
        repeat (20) @(negedge clk_uart);
        chk("fs_no_valid", rx_valid, 0);

        // Overrun: back-to-back frames, never accepted
        ovr_base = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk_uart);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_pulses", ovr_cnt - ovr_base, 1);
        chk("ovr_low_after", overrun_err, 0);
        accept();

        // Accept coincides with second completion
        ovr_base = ovr_cnt;
        fork
            begin
                send_frame(8'h11, 1'b0, 1'b1, 1'b0);
                send_frame(8'h22, 1'b0, 1'b1, 1'b0);
            end
            begin
                repeat (345 + LAT) @(negedge clk_uart);
                chk("sim_pre_data", rx_data, 8'h11);
                chk("sim_pre_valid", rx_valid, 1);
                rx_ready = 1'b1;
                @(negedge clk_uart);
                rx_ready = 1'b0;
            end
        join
        chk("sim_data", rx_data, 8'h22);
        chk("sim_valid", rx_valid, 1);
        chk("sim_no_ovr", ovr_cnt - ovr_base, 0);
        accept();

        // Reset mid-data with the line low
        rx = 1'b0;
        repeat (40) @(negedge clk_uart);
        chk("mid_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("mrst_data", rx_data, 0);
        chk("mrst_valid", rx_valid, 0);
        chk("mrst_perr", parity_err, 0);
        chk("mrst_ferr", frame_err, 0);
        chk("mrst_ovr", overrun_err, 0);
        chk("mrst_busy", busy, 0);
        repeat (2) @(negedge clk_uart);
        rst = 1'b1;
        repeat (5) @(negedge clk_uart);
        chk("mrst_wait_busy", busy, 1);
        chk("mrst_wait_valid", rx_valid, 0);
        rx = 1'b1;
        repeat (3 + LAT) @(negedge clk_uart);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        chk("post_valid", rx_valid, 1);
        chk("post_data", rx_data, 8'h5A);
        chk("post_perr", parity_err, 0);
        chk("post_ferr", frame_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Serial UART receiver, the receiving end of the team's UART frame format: start (0), DATA_BITS data bits LSB first, one parity bit (even by default, i.e. ^data), stop (1). It oversamples the line with a baud counter, samples each bit at mid-bit, checks parity and stop, and presents the byte on a valid/ready parallel interface. It sits between the serial line rx and the system-side consumer.

Parameters:
CLKS_PER_BIT, 16, clk_uart cycles per bit; must be even and >= 4
DATA_BITS, 8, data bits per frame (1..8)
PARITY_ODD, 0, 0 = expect even parity (^data); 1 = expect odd parity (~^data)

Ports:
clk_uart  input  1  single clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset
rx  input  1  serial line, idle high
rx_ready  input  1  consumer accepts rx_data when high with rx_valid
rx_data  output  DATA_BITS  received data, LSB = first bit on line
rx_valid  output  1  rx_data and error flags valid
parity_err  output  1  parity mismatch on the frame in rx_data
frame_err  output  1  stop bit sampled 0 on the frame in rx_data
overrun_err  output  1  one-cycle pulse: completed frame dropped
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous): rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun_err=0, busy=0 (WAIT_HIGH forces busy=1 after release), counters=0, state=WAIT_HIGH.
- States: WAIT_HIGH, IDLE, START, DATA, PARITY, STOP.
- WAIT_HIGH: wait for rx=1, then IDLE. A line held low does not start a frame.
- IDLE: rx=0 -> START, baud cnt=0.
- START: cnt increments each cycle. At cnt=CLKS_PER_BIT/2-1, sample rx. If 0 -> DATA, cnt=0, bit_idx=0. If 1, false start -> IDLE, nothing reported.
- DATA: at cnt=CLKS_PER_BIT-1, sample rx into shift[bit_idx], bit_idx+1, cnt=0. After bit DATA_BITS-1 -> PARITY.
- PARITY: at cnt=CLKS_PER_BIT-1, compare rx with expected parity and latch mismatch -> STOP.
- STOP: at cnt=CLKS_PER_BIT-1, sample stop bit. Complete the frame; stop=1 -> IDLE; stop=0 -> WAIT_HIGH (break/frame error).
- Exit at mid-stop resynchronises on the next falling edge.
- Completion: on the edge after the stop sample, load rx_data, parity_err and frame_err, and set rx_valid=1. Latency from entering START: CLKS_PER_BIT/2 + (DATA_BITS+2)*CLKS_PER_BIT cycles to the stop sample, +1 to rx_valid (169 for defaults).
- Frames with errors are still delivered, with the flags set.
- Handshake: rx_valid holds, and rx_data and flags stay stable, until an edge with rx_valid & rx_ready. That edge clears rx_valid.
- Overrun: frame completes while rx_valid=1 and rx_ready=0 -> new frame discarded, old data kept, overrun_err=1 for exactly one cycle.
- Simultaneous accept and completion: the new frame loads, rx_valid stays 1, no overrun.
- rx_ready while rx_valid=0 has no effect.
- Reset mid-frame aborts the frame and returns to WAIT_HIGH.

Optional Feature:
UART_RX_SYNC_EN
- Defined: rx passes through a 2-flop synchronizer (flops reset to 1) before the FSM. All latencies +2 cycles.
- Undefined: rx is used directly and must be synchronous to clk_uart.

Test Plan:
- Defaults, send 0xA5 with parity 0, stop 1, rx_ready=0 -> rx_valid=1, rx_data=0xA5, both errors 0. Held until rx_ready=1, then rx_valid=0 next cycle.
- Send 0x37 with parity bit 0 (expected 1) -> rx_data=0x37, parity_err=1, frame_err=0.
- Send 0x0F with stop bit 0, hold rx low 50 bit times -> frame_err=1, rx_data=0x0F, busy=1. No further frames until rx=1.
- rx low for 4 cycles then high -> no rx_valid; busy returns 0 by 9 cycles after the falling edge.
- Back-to-back 0x11 and 0x22 with rx_ready=0 -> rx_data stays 0x11. overrun_err pulses 1 cycle at the second completion.
- Repeat with rx_ready pulsed the same cycle as the second completion -> rx_data=0x22, no overrun.
- Assert rst mid-data with rx held low -> all outputs 0. After rx=1 then a 0x5A frame -> rx_data=0x5A, no errors.
